oam_dma_controller: RTL
=======================

// Module: oam_dma_controller
// PURPOSE
//  Bus initiator that copies 160 bytes from XX00-XX9F into object RAM FE00-FE9F when the CPU writes XX to FF46.
//  Snoops the CPU bus for the FF46 register and drives a separate master port into the system bus mux.
//  dma_active tells the top level to hand the bus to this block; object RAM sees ordinary bus reads/writes.
// PARAMETERS
//  START_DELAY  4  clocks between the FF46 write and the first read (>=1)
//  BYTE_CYCLES  4  clocks per byte copied (>=2): 1 read + 1 write + (BYTE_CYCLES-2) idle
// PORTS
//  clock           in   1   system clock, all logic on posedge
//  nreset          in   1   synchronous, active-low reset
//  address_bus     in   16  CPU bus address
//  data_bus_write  in   8   CPU write data
//  data_bus_read   out  8   FF46 readback when nread==0 && address_bus==FF46, else 8'bZ
//  nread           in   1   CPU read strobe, active low
//  nwrite          in   1   CPU write strobe, active low
//  dma_active      out  1   1 while the transfer owns the bus
//  dma_address     out  16  master address
//  dma_data_write  out  8   master write data
//  dma_data_read   in   8   master read data (combinational from the addressed memory)
//  dma_nread       out  1   master read strobe, active low
//  dma_nwrite      out  1   master write strobe, active low
// BEHAVIOUR
//  - Reset values (nreset==0 at posedge): src_reg=8'hFF, state=IDLE, dma_active=0, dma_nread=1, dma_nwrite=1,
//    dma_address=16'h0000, dma_data_write=8'h00, byte index=0. Reset mid-transfer aborts at once; no further writes.
//  - Trigger: posedge with nwrite==0 && address_bus==16'hFF46 -> src_reg<=data_bus_write; state IDLE->START.
//  - Source remap: the effective high byte is src_reg-8'h20 when src_reg>=8'hE0 (echo RAM); otherwise src_reg.
//  - States: IDLE -> START (START_DELAY clocks) -> READ -> WRITE -> WAIT (BYTE_CYCLES-2 clocks, skipped if 0) -> READ ...
//  - dma_active=1 in READ, WRITE and WAIT only; 0 in IDLE and START.
//  - READ (1 clock): dma_address={src_hi,idx}, dma_nread=0; dma_data_read is latched at the posedge ending READ.
//  - WRITE (1 clock): dma_address=16'hFE00+idx, dma_data_write=latched byte, dma_nwrite=0. Strobes are 1 in every other state.
//  - idx increments after WRITE. After idx==159 is written -> IDLE; dma_active falls the next clock.
//  - Total latency from trigger posedge to dma_active low: START_DELAY + 160*BYTE_CYCLES clocks.
//  - FF46 reads return src_reg (the raw value, not the remapped one) at any time, including during a transfer.
//  - idx is 8 bits and never wraps past 159; the destination never leaves FE00-FE9F.
//  - A CPU bus write to any address other than FF46 is ignored by this block.
// CONFIGURATION
//  DMA_RESTART_EN defined: an FF46 write while state!=IDLE updates src_reg, sets idx=0 and re-enters START.
//    An in-flight byte is abandoned, not written.
//  DMA_RESTART_EN undefined: FF46 writes while state!=IDLE are ignored completely (src_reg unchanged).
//    The transfer finishes from the original source.
// STRUCTURE
//  - Shared include lcd_defs.vh holds DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_SIZE=160,
//    ECHO_HI=8'hE0 and the state encodings (IDLE, START, READ, WRITE, WAIT).
//  - Single module with no sub-modules. The delay/wait counter and idx live inline with the FSM.
// TESTING
//  - Reset: hold nreset=0 for 2 clocks -> dma_active=0, dma_nread=dma_nwrite=1, FF46 read returns 8'hFF.
//  - Write 8'hC1 to FF46 with a RAM model preloaded with C100+i=i^8'h5A
//    -> after 4+640 clocks, FE00+i==i^8'h5A for i=0..159 and there are exactly 160 dma_nwrite pulses.
//  - Cycle check with the same transfer: the first dma_nread=0 comes 4 clocks after the trigger at C100,
//    the first dma_nwrite=0 comes the next clock at FE00, and the last write is at FE9F.
//  - Write 8'hE3 -> reads are issued at C300-C39F; an FF46 read returns 8'hE3.
//  - Write 8'hC1, then 8'hD0 at clock 100.
//    With DMA_RESTART_EN: idx resets and the final OAM contents come from D000.
//    Without it: OAM contents come from C100 and FF46 reads 8'hC1.
//  - Pull nreset low at clock 300 mid-transfer -> no further dma_nwrite pulses, FE00+i for i>=75 is unchanged,
//    and dma_active=0 on the next clock.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
//------------------------------------------------------------------------------
// Module   : oam_dma_controller_pkg
// Brief    : Shared addresses, sizes and state encodings for the OAM DMA block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package oam_dma_controller_pkg;

  localparam logic [15:0] c_dma_reg_addr = 16'hFF46;
  localparam logic [15:0] c_oam_base     = 16'hFE00;
  localparam int          c_oam_size     = 160;
  localparam logic [7:0]  c_echo_hi      = 8'hE0;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_start = 3'd1;
  localparam logic [2:0] c_st_read  = 3'd2;
  localparam logic [2:0] c_st_write = 3'd3;
  localparam logic [2:0] c_st_wait  = 3'd4;

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so those pages are fetched 0x20 lower.
  function automatic logic [7:0] src_high(input logic [7:0] src);
    return (src >= c_echo_hi) ? (src - 8'h20) : src;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oam_dma_controller.sv
//------------------------------------------------------------------------------
// Module   : oam_dma_controller
// Brief    : Copies XX00-XX9F into object RAM FE00-FE9F after a CPU write of XX
//            to FF46. Define DMA_RESTART_EN to let FF46 writes restart a transfer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int START_DELAY = 4,
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] address_bus,
  input  logic [7:0]  data_bus_write,
  output logic [7:0]  data_bus_read,
  input  logic        nread,
  input  logic        nwrite,
  output logic        dma_active,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_data_write,
  input  logic [7:0]  dma_data_read,
  output logic        dma_nread,
  output logic        dma_nwrite
);

  localparam int              CNT_W        = 16;
  localparam logic [7:0]      c_last_idx   = 8'(c_oam_size - 1);
  localparam logic [CNT_W-1:0] c_start_load = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] c_wait_load  = CNT_W'((BYTE_CYCLES > 2) ? (BYTE_CYCLES - 3) : 0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             trig;

  assign trig          = !nwrite && (address_bus == c_dma_reg_addr);
  assign data_bus_read = (!nread && (address_bus == c_dma_reg_addr)) ? src_q : 8'bz;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      idx_q   <= 8'h00;
      src_q   <= 8'hFF;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    src_d   = src_q;
    byte_d  = byte_q;
    last_d  = last_q;
    case (state_q)
      c_st_idle: ;
      c_st_start: begin
        if (cnt_q == '0) state_d = c_st_read;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      c_st_read: begin
        byte_d  = dma_data_read;
        state_d = c_st_write;
      end
      c_st_write: begin
        // idx parks on the final byte; last_q remembers the copy is complete.
        if (idx_q == c_last_idx) last_d = 1'b1;
        else                     idx_d  = idx_q + 8'd1;
        if (BYTE_CYCLES > 2) begin
          state_d = c_st_wait;
          cnt_d   = c_wait_load;
        end else begin
          state_d = (idx_q == c_last_idx) ? c_st_idle : c_st_read;
        end
      end
      c_st_wait: begin
        if (cnt_q == '0) state_d = last_q ? c_st_idle : c_st_read;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = c_st_idle;
    endcase

`ifdef DMA_RESTART_EN
    if (trig) begin
`else
    if (trig && (state_q == c_st_idle)) begin
`endif
      src_d   = data_bus_write;
      idx_d   = 8'h00;
      last_d  = 1'b0;
      cnt_d   = c_start_load;
      state_d = c_st_start;
    end
  end

  always_comb begin
    dma_active     = 1'b0;
    dma_nread      = 1'b1;
    dma_nwrite     = 1'b1;
    dma_address    = 16'h0000;
    dma_data_write = 8'h00;
    case (state_q)
      c_st_read: begin
        dma_active  = 1'b1;
        dma_nread   = 1'b0;
        dma_address = {src_high(src_q), idx_q};
      end
      c_st_write: begin
        dma_active     = 1'b1;
        dma_nwrite     = 1'b0;
        dma_address    = c_oam_base + {8'h00, idx_q};
        dma_data_write = byte_q;
      end
      c_st_wait: dma_active = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
